drop_time_sqrt: RTL and testbench



---
 rtl/drop_time_sqrt.sv | 124 ++++++++++++
 tb/tb_drop_time_sqrt.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/drop_time_sqrt.sv
// Restoring digit-by-digit square root, one result bit per clock, start/busy/done handshake.
// Optional round-to-nearest output enabled by defining DROP_TIME_SQRT_ROUND_EN.
module drop_time_sqrt #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] radicand,
    output logic [WIDTH-1:0] t_act,
    output logic             busy,
    output logic             done
);
    localparam int ITER   = WIDTH / 2 + FRAC_BITS;
    localparam int WORK_W = WIDTH + 2 * FRAC_BITS;
    localparam int REM_W  = ITER + 2;
    localparam int CNT_W  = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [ITER-1:0]     root_q, root_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    t_act_q, t_act_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [REM_W-1:0]    rem_shift;
    logic [REM_W-1:0]    trial;
    logic                take;
    logic [WIDTH-1:0]    result;

    // Remainder never grows past REM_W bits, so the top two bits shifted out are always zero.
    assign rem_shift = REM_W'({rem_q, work_q[WORK_W-1 -: 2]});
    assign trial     = {root_q, 2'b01};
    assign take      = (rem_shift >= trial);

`ifdef DROP_TIME_SQRT_ROUND_EN
    logic [WIDTH:0] root_inc;
    assign root_inc = (WIDTH + 1)'(root_q) + (WIDTH + 1)'(1);
    always_comb begin
        result = WIDTH'(root_q);
        if (rem_q > REM_W'(root_q)) begin
            result = root_inc[WIDTH] ? '1 : root_inc[WIDTH-1:0];
        end
    end
`else
    assign result = WIDTH'(root_q);
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        t_act_d = t_act_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = WORK_W'(radicand) << (2 * FRAC_BITS);
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CNT_W'(ITER);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                work_d = work_q << 2;
                rem_d  = take ? (rem_shift - trial) : rem_shift;
                root_d = (root_q << 1) | ITER'(take);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                t_act_d = result;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            t_act_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            t_act_q <= t_act_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign t_act = t_act_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_drop_time_sqrt.sv
// Self-checking bench for drop_time_sqrt against an integer square-root reference.
module tb_drop_time_sqrt;
    localparam int WIDTH     = 16;
    localparam int FRAC_BITS = 8;
    localparam int LAT       = WIDTH / 2 + FRAC_BITS + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] radicand = '0;
    logic [WIDTH-1:0] t_act;
    logic             busy;
    logic             done;

    int checks = 0;
    int failures = 0;

    drop_time_sqrt #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .radicand(radicand),
        .t_act(t_act), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned lo = 0, hi = 64'd1 << 20, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] r);
        longint unsigned x, s;
        x = longint'(r) << (2 * FRAC_BITS);
        s = isqrt(x);
`ifdef DROP_TIME_SQRT_ROUND_EN
        if (x - s * s > s) s = s + 1;
        if (s >= (64'd1 << WIDTH)) s = (64'd1 << WIDTH) - 1;
`endif
        return WIDTH'(s);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle start, then wait for done; checks latency, result and pulse width.
    task automatic run(input logic [WIDTH-1:0] r, input string tag);
        int n = 0;
        radicand = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        while (!done && n < 3 * LAT) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_val"}, t_act, model(r));
        chk({tag, "_busy_lo"}, busy, 0);
        tick();
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, t_act, model(r));
    endtask

    initial begin
        int ndone;
        int last;
        // Reset with start asserted
        start = 1'b1;
        radicand = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tact", t_act, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        start = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);

        // Directed values
        run(16'd1, "r1");
        chk("r1_const", t_act, 16'h0100);
        run(16'd0, "r0");
        chk("r0_const", t_act, 16'h0000);
        run(16'd2, "r2");
        chk("r2_const", t_act, 16'h016A);
        run(16'd10, "r10");
`ifdef DROP_TIME_SQRT_ROUND_EN
        chk("r10_const", t_act, 16'h032A);
`else
        chk("r10_const", t_act, 16'h0329);
`endif
        run(16'hFFFF, "rmax");
        chk("rmax_const", t_act, 16'hFFFF);

        // Random radicands
        for (int i = 0; i < 20; i++) begin
            run(WIDTH'($urandom), "rand");
        end

        // Start ignored while busy, radicand changes after capture
        radicand = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i < 3 * LAT; i++) begin
            start = (i == 5);
            radicand = (i == 5) ? 16'd9 : WIDTH'($urandom);
            tick();
            if (done) begin
                ndone++;
                chk("ign_val", t_act, 16'h0200);
            end
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);

        // Reset mid-operation
        radicand = WIDTH'($urandom_range(100, 65535));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_tact", t_act, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        chk("abort_tact2", t_act, 0);

        // Back-to-back with start held
        radicand = 16'd16;
        start = 1'b1;
        tick();
        ndone = 0;
        last = 0;
        for (int i = 1; i < 5 * (LAT + 1) && ndone < 4; i++) begin
            tick();
            if (done) begin
                chk("b2b_val", t_act, 16'h0400);
                chk("b2b_gap", i - last, (ndone == 0) ? LAT : LAT + 1);
                last = i;
                ndone++;
            end
        end
        chk("b2b_ndone", ndone, 4);
        start = 1'b0;
        for (int i = 0; i < LAT + 2; i++) tick();
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
